qs_fifo: RTL and testbench
==========================

// Module: qs_fifo
// PURPOSE
//   Single-clock, synchronous first-in/first-out buffer of DATA_W-bit words, DEPTH entries deep.
//   Decouples a producer and a consumer inside the MAC datapath with a simple push/pop handshake.
//   Exposes full/empty flags and a registered read-data output.
// PARAMETERS
//   DATA_W  8  width of each stored word in bits (>=1)
//   DEPTH   4  number of storage entries (>=2; any value, need not be a power of two)
// PORTS
//   clk          in   1       clock; all state changes on the rising edge
//   rst          in   1       asynchronous, active-high reset
//   push_i       in   1       write request; sampled on rising clk
//   push_data_i  in   DATA_W  word written when a push is accepted
//   pop_i        in   1       read request; sampled on rising clk
//   pop_data_o   out  DATA_W  registered word from the most recently accepted pop
//   full_o       out  1       1 when DEPTH words are stored
//   empty_o      out  1       1 when no words are stored
// BEHAVIOUR
//   - Reset (asserted at any time, including mid-operation): wr_ptr=0, rd_ptr=0, count=0,
//     pop_data_o=0, empty_o=1, full_o=0. Storage contents need not be cleared.
//   - State: storage array [DEPTH], wr_ptr, rd_ptr, count. Pointers are clog2(DEPTH) bits wide.
//     count is clog2(DEPTH+1) bits wide.
//   - pop_ok  = pop_i && !empty_o.
//   - push_ok = push_i && (!full_o || pop_ok).
//   - push_ok: mem[wr_ptr] <= push_data_i. wr_ptr advances by 1 and wraps DEPTH-1 -> 0.
//   - pop_ok: pop_data_o <= mem[rd_ptr]. rd_ptr advances by 1 and wraps DEPTH-1 -> 0.
//   - Read latency is one cycle: the data is valid on pop_data_o right after the accepting edge.
//   - pop_data_o holds its value on every cycle without pop_ok.
//   - count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
//   - full_o = (count==DEPTH); empty_o = (count==0). Both are derived from registered count.
//   - Push while full with no pop: ignored. Data, pointers and count are unchanged; no overwrite.
//   - Pop while empty: ignored. pop_data_o holds; no underflow; pointers and count are unchanged.
//   - Simultaneous push+pop when empty: only the push takes effect. There is no fall-through;
//     the new word is readable from the next cycle.
//   - Simultaneous push+pop when full: both take effect. Count stays DEPTH and full_o stays 1.
//   - Simultaneous push+pop otherwise: both take effect and count is unchanged.
//   - Level-sensitive requests: holding push_i or pop_i high for N edges performs N operations,
//     each subject to the rules above.
//   - Order is strictly preserved across pointer wrap-around.
// TESTING
//   1. Assert rst, then release -> empty_o=1, full_o=0, pop_data_o=8'h00.
//      No push/pop for 10 cycles -> all outputs unchanged.
//   2. Push 8'h11, 8'h22, 8'h33, 8'h44, one per cycle -> empty_o=0 after the 1st edge,
//      full_o=1 after the 4th. A 5th push of 8'h55 is ignored.
//   3. From full, pop 4 times -> pop_data_o = 11, 22, 33, 44 in order; empty_o=1 after the
//      4th pop. Six further pops -> pop_data_o stays 8'h44 and empty_o stays 1.
//   4. Wrap-around: push 3, pop 3, then push A1..A4 and pop 4 -> A1..A4 in order, full_o
//      asserted exactly after A4.
//   5. Simultaneous push/pop: when full, pop+push 8'h77 -> head word returned, full_o stays 1,
//      8'h77 read last. When empty, pop+push 8'h66 -> pop_data_o unchanged, empty_o=0,
//      next pop returns 8'h66.
//   6. Assert rst asynchronously, between edges, with 2 words stored -> empty_o=1, full_o=0 and
//      pop_data_o=0 immediately. A subsequent pop is ignored.

Source files
------------

// File: rtl/qs_fifo.sv
// qs_fifo: single-clock FIFO with full/empty flags and a registered pop data output
module qs_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              push_ok, pop_ok;

    assign full_o     = count_q == CW'(DEPTH);
    assign empty_o    = count_q == '0;
    assign pop_data_o = pop_data_q;

    // Accept decisions, pointer wrap and occupancy update; a pop frees room for a push when full
    always_comb begin
        pop_ok     = pop_i && !empty_o;
        push_ok    = push_i && (!full_o || pop_ok);
        wr_ptr_d   = push_ok ? (wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop_ok ? (rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d    = (push_ok && !pop_ok) ? count_q + 1'b1 :
                     (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
        pop_data_d = pop_ok ? mem_q[rd_ptr_q] : pop_data_q;
    end

    // Control state and read register, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Storage is not reset; only slots behind valid pointers are ever read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: tb/tb_qs_fifo.sv
// tb_qs_fifo: randomized and directed checks of qs_fifo against a queue-based reference model
module tb_qs_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_i, pop_i;
    logic [7:0] push_data_i;
    logic [7:0] pop_data_o;
    logic       full_o, empty_o;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] m_data;

    qs_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push_i(push_i), .push_data_i(push_data_i),
        .pop_i(pop_i), .pop_data_o(pop_data_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    // One clock with the given requests; the model applies the FIFO rules at the same edge
    task automatic cyc(input bit pu, input bit po, input logic [7:0] d);
        bit pop_ok, push_ok;
        push_i = pu;
        pop_i = po;
        push_data_i = d;
        @(posedge clk);
        #1;
        pop_ok = po && q.size() > 0;
        push_ok = pu && (q.size() < DEPTH || pop_ok);
        if (pop_ok) m_data = q.pop_front();
        if (push_ok) q.push_back(d);
        push_i = 1'b0;
        pop_i = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++;
        if (pop_data_o !== 8'h00 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: data=%h empty=%b full=%b, want 00 1 0", pop_data_o, empty_o, full_o);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 8'($urandom));
            n_chk++;
            if (pop_data_o !== 8'h00 || empty_o !== 1'b1 || full_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle[%0d]: data=%h empty=%b full=%b, want 00 1 0", i, pop_data_o, empty_o, full_o);
            end
        end
    endtask

    task automatic test_fill;
        logic [7:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, v[i]);
            n_chk++;
            if (empty_o !== 1'b0 || full_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL fill[%0d]: empty=%b full=%b, want 0 %b", i, empty_o, full_o, i == 3);
            end
        end
        cyc(1, 0, 8'h55);
        n_chk++;
        if (full_o !== 1'b1 || q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL overflow: full=%b model_size=%0d, want 1 %0d", full_o, q.size(), DEPTH);
        end
    endtask

    task automatic test_drain;
        logic [7:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'h00);
            n_chk++;
            if (pop_data_o !== v[i] || empty_o !== (i == 3) || full_o !== 1'b0) begin
                n_fail++;
                $display("FAIL drain[%0d]: data=%h empty=%b full=%b, want %h %b 0",
                         i, pop_data_o, empty_o, full_o, v[i], i == 3);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 8'h00);
            n_chk++;
            if (pop_data_o !== 8'h44 || empty_o !== 1'b1) begin
                n_fail++;
                $display("FAIL underflow[%0d]: data=%h empty=%b, want 44 1", i, pop_data_o, empty_o);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] b[3] = '{8'hB1, 8'hB2, 8'hB3};
        logic [7:0] a[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 3; i++) cyc(1, 0, b[i]);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'h00);
            n_chk++;
            if (pop_data_o !== b[i]) begin
                n_fail++;
                $display("FAIL wrap_pre[%0d]: data=%h, want %h", i, pop_data_o, b[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, a[i]);
            n_chk++;
            if (full_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_full[%0d]: full=%b, want %b", i, full_o, i == 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'h00);
            n_chk++;
            if (pop_data_o !== a[i] || empty_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_pop[%0d]: data=%h empty=%b, want %h %b", i, pop_data_o, empty_o, a[i], i == 3);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] c[5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h77};
        for (int i = 0; i < 4; i++) cyc(1, 0, c[i]);
        cyc(1, 1, 8'h77);
        n_chk++;
        if (pop_data_o !== 8'hC1 || full_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_full: data=%h full=%b, want c1 1", pop_data_o, full_o);
        end
        for (int i = 1; i < 5; i++) begin
            cyc(0, 1, 8'h00);
            n_chk++;
            if (pop_data_o !== c[i] || empty_o !== (i == 4)) begin
                n_fail++;
                $display("FAIL pp_drain[%0d]: data=%h empty=%b, want %h %b", i, pop_data_o, empty_o, c[i], i == 4);
            end
        end
        cyc(1, 1, 8'h66);
        n_chk++;
        if (pop_data_o !== 8'h77 || empty_o !== 1'b0 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_empty: data=%h empty=%b full=%b, want 77 0 0", pop_data_o, empty_o, full_o);
        end
        cyc(0, 1, 8'h00);
        n_chk++;
        if (pop_data_o !== 8'h66 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_next: data=%h empty=%b, want 66 1", pop_data_o, empty_o);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            n_chk++;
            if (pop_data_o !== m_data || full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0)) begin
                n_fail++;
                $display("FAIL random[%0d]: data=%h full=%b empty=%b, want %h %b %b",
                         i, pop_data_o, full_o, empty_o, m_data, q.size() == DEPTH, q.size() == 0);
            end
        end
    endtask

    task automatic test_async_reset;
        while (q.size() > 0) cyc(0, 1, 8'h00);
        cyc(1, 0, 8'hD1);
        cyc(1, 0, 8'hD2);
        cyc(0, 1, 8'h00);
        cyc(1, 0, 8'hD3);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (pop_data_o !== 8'h00 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: data=%h empty=%b full=%b, want 00 1 0", pop_data_o, empty_o, full_o);
        end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_data = 8'h00;
        cyc(0, 1, 8'h00);
        n_chk++;
        if (pop_data_o !== 8'h00 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_pop: data=%h empty=%b, want 00 1", pop_data_o, empty_o);
        end
        cyc(1, 0, 8'hE5);
        cyc(0, 1, 8'h00);
        n_chk++;
        if (pop_data_o !== 8'hE5 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_use: data=%h empty=%b, want e5 1", pop_data_o, empty_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        push_i = 1'b0;
        pop_i = 1'b0;
        push_data_i = 8'h00;
        m_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
